// File: rtl/mem_copy_initiator.sv
// Copy engine driving one read and one write port of the block memory controller.
// Reads are credit-limited so that in-flight data always fits the internal FIFO.
module mem_copy_initiator #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int LEN_W      = 13,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_gnt,
  input  logic              rd_valid,
  input  logic [DATA_W-1:0] rd_data,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic              wr_gnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state;
  logic [LEN_W-1:0]  rd_left;
  logic [LEN_W-1:0]  wr_left;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W-1:0]  outstanding;
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [CNT_W:0]    in_flight;
  logic              run;
  logic              rd_fire;
  logic              wr_fire;
  logic              push;

  assign run       = (state == S_RUN);
  assign busy      = run;
  assign done      = (state == S_DONE);
  // Words already buffered plus words still on their way back.
  assign in_flight = {1'b0, fifo_count} + {1'b0, outstanding};
  assign rd_req    = run && (rd_left != '0) && (in_flight < (CNT_W+1)'(FIFO_DEPTH));
  assign wr_req    = run && (fifo_count != '0);
  assign wr_data   = fifo_mem[head];
  assign rd_fire   = rd_req && rd_gnt;
  assign wr_fire   = wr_req && wr_gnt;
  assign push      = run && rd_valid && (outstanding != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      err         <= 1'b0;
      rd_addr     <= '0;
      wr_addr     <= '0;
      rd_left     <= '0;
      wr_left     <= '0;
      fifo_count  <= '0;
      outstanding <= '0;
      head        <= '0;
      tail        <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          rd_addr <= src_addr;
          wr_addr <= dst_addr;
          rd_left <= len;
          wr_left <= len;
          err     <= 1'b0;
          state   <= S_RUN;
        end
        S_RUN: if ((wr_left == '0) || (wr_fire && (wr_left == LEN_W'(1)))) state <= S_DONE;
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      if (rd_fire) begin
        rd_addr <= rd_addr + ADDR_W'(1);
        rd_left <= rd_left - LEN_W'(1);
      end
      if (wr_fire) begin
        wr_addr <= wr_addr + ADDR_W'(1);
        wr_left <= wr_left - LEN_W'(1);
        head    <= head + PTR_W'(1);
      end
      if (push) begin
        fifo_mem[tail] <= rd_data;
        tail           <= tail + PTR_W'(1);
      end

      case ({push, wr_fire})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
      case ({rd_fire, push})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase

      // Data returned with nothing requested is dropped and flagged.
      if (run && rd_valid && (outstanding == '0)) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_copy_initiator.sv
// Directed bench for mem_copy_initiator; the bench plays the memory controller
// (read data = pattern of the address, returned one cycle after the grant).
module tb_mem_copy_initiator;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [11:0] src_addr = '0;
  logic [11:0] dst_addr = '0;
  logic [12:0] len = '0;
  logic        busy, done, err;
  logic        rd_req, wr_req;
  logic [11:0] rd_addr, wr_addr;
  logic [31:0] wr_data;
  logic        rd_gnt = 1'b1;
  logic        wr_gnt = 1'b1;
  logic        rd_valid;
  logic [31:0] rd_data;

  logic        rsp_valid = 1'b0;
  logic [31:0] rsp_data = '0;
  logic        inj = 1'b0;
  logic [31:0] inj_data = '0;

  logic [11:0] rd_log[$];
  logic [11:0] wa_log[$];
  logic [31:0] wd_log[$];
  int          done_cnt = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  mem_copy_initiator dut (
    .clk(clk), .reset(reset), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .len(len), .busy(busy), .done(done), .err(err), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data), .wr_req(wr_req),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt)
  );

  function automatic logic [31:0] pat(input logic [11:0] a);
    return 32'hC0DE_0000 | {20'h0, a};
  endfunction

  assign rd_valid = rsp_valid | inj;
  assign rd_data  = inj ? inj_data : rsp_data;

  always @(posedge clk) begin
    rsp_valid <= rd_req & rd_gnt;
    rsp_data  <= pat(rd_addr);
    if (!reset) begin
      if (rd_req && rd_gnt) rd_log.push_back(rd_addr);
      if (wr_req && wr_gnt) begin
        wa_log.push_back(wr_addr);
        wd_log.push_back(wr_data);
      end
      if (done) done_cnt++;
    end
  end

  task automatic clear_logs();
    rd_log.delete();
    wa_log.delete();
    wd_log.delete();
    done_cnt = 0;
  endtask

  // Returns at the falling edge after the start edge (state now RUN).
  task automatic start_cmd(input logic [11:0] s, input logic [11:0] d, input logic [12:0] l);
    @(negedge clk);
    src_addr = s; dst_addr = d; len = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int cyc);
    cyc = 1;
    while (!done && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_done: timeout after %0d cycles, done=%b expected 1", cyc, done);
    end
  endtask

  task automatic check_copy(input string name, input logic [11:0] s, input logic [11:0] d, input int l);
    n_checks++;
    if (wa_log.size() != l) begin
      n_fail++;
      $display("FAIL %s wr_count: got %0d expected %0d", name, wa_log.size(), l);
    end
    for (int i = 0; i < l && i < wa_log.size(); i++) begin
      n_checks++;
      if (wa_log[i] !== d + 12'(i) || wd_log[i] !== pat(s + 12'(i))) begin
        n_fail++;
        $display("FAIL %s word%0d: got addr %h data %h expected addr %h data %h",
                 name, i, wa_log[i], wd_log[i], d + 12'(i), pat(s + 12'(i)));
      end
    end
  endtask

  task automatic check_outputs_zero(input string name);
    n_checks++;
    if ({busy, done, err, rd_req, wr_req} !== 5'b0 || rd_addr !== 12'h0 ||
        wr_addr !== 12'h0 || wr_data !== 32'h0) begin
      n_fail++;
      $display("FAIL %s: got busy=%b done=%b err=%b rd_req=%b wr_req=%b rd_addr=%h wr_addr=%h wr_data=%h expected all 0",
               name, busy, done, err, rd_req, wr_req, rd_addr, wr_addr, wr_data);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset_state");
    reset = 1'b0;
    @(negedge clk);
    check_outputs_zero("after_reset");
  endtask

  task automatic test_basic();
    int cyc;
    clear_logs();
    rd_gnt = 1'b1; wr_gnt = 1'b1;
    start_cmd(12'h010, 12'h800, 13'd4);
    wait_done(50, cyc);
    n_checks++;
    if (cyc !== 7) begin
      n_fail++;
      $display("FAIL basic_latency: done after %0d cycles expected 7", cyc);
    end
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (i >= rd_log.size() || rd_log[i] !== 12'h010 + 12'(i)) begin
        n_fail++;
        $display("FAIL basic_rd%0d: got %h expected %h", i, (i < rd_log.size()) ? rd_log[i] : 12'hxxx, 12'h010 + 12'(i));
      end
    end
    check_copy("basic", 12'h010, 12'h800, 4);
    n_checks++;
    if (done_cnt !== 1 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_end: got done_cnt=%0d busy=%b done=%b expected 1 0 0", done_cnt, busy, done);
    end
  endtask

  task automatic test_len0();
    clear_logs();
    start_cmd(12'h123, 12'h456, 13'd0);
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL len0_run: got busy=%b done=%b expected 1 0", busy, done);
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL len0_done: got busy=%b done=%b expected 0 1", busy, done);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || done_cnt !== 1 || rd_log.size() != 0 || wa_log.size() != 0) begin
      n_fail++;
      $display("FAIL len0_end: got done=%b done_cnt=%0d reads=%0d writes=%0d expected 0 1 0 0",
               done, done_cnt, rd_log.size(), wa_log.size());
    end
  endtask

  task automatic test_stall();
    int cyc;
    clear_logs();
    rd_gnt = 1'b1; wr_gnt = 1'b0;
    start_cmd(12'h100, 12'h200, 13'd10);
    repeat (20) @(negedge clk);
    n_checks++;
    if (rd_log.size() != 4 || rd_req !== 1'b0 || wr_req !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_credit: got reads=%0d rd_req=%b wr_req=%b expected 4 0 1",
               rd_log.size(), rd_req, wr_req);
    end
    wr_gnt = 1'b1;
    wait_done(100, cyc);
    @(negedge clk);
    check_copy("stall", 12'h100, 12'h200, 10);
  endtask

  task automatic test_wrap();
    int cyc;
    logic [11:0] exp_rd [4];
    exp_rd = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
    clear_logs();
    start_cmd(12'hFFE, 12'h300, 13'd4);
    wait_done(50, cyc);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (i >= rd_log.size() || rd_log[i] !== exp_rd[i]) begin
        n_fail++;
        $display("FAIL wrap_rd%0d: got %h expected %h", i, (i < rd_log.size()) ? rd_log[i] : 12'hxxx, exp_rd[i]);
      end
    end
    check_copy("wrap", 12'hFFE, 12'h300, 4);
  endtask

  task automatic test_reset_mid();
    int cyc;
    clear_logs();
    start_cmd(12'h020, 12'h400, 13'd8);
    cyc = 0;
    while (wa_log.size() < 3 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    reset = 1'b1;
    @(negedge clk);
    check_outputs_zero("reset_mid");
    reset = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if (done_cnt !== 0 || busy !== 1'b0 || wa_log.size() != 3) begin
      n_fail++;
      $display("FAIL reset_mid_abort: got done_cnt=%0d busy=%b writes=%0d expected 0 0 3",
               done_cnt, busy, wa_log.size());
    end
    clear_logs();
    start_cmd(12'h030, 12'h500, 13'd2);
    wait_done(50, cyc);
    @(negedge clk);
    check_copy("after_abort", 12'h030, 12'h500, 2);
  endtask

  task automatic test_err();
    int cyc;
    clear_logs();
    rd_gnt = 1'b0; wr_gnt = 1'b0;
    start_cmd(12'h040, 12'h600, 13'd4);
    inj_data = 32'hDEAD_BEEF;
    inj = 1'b1;
    @(negedge clk);
    inj = 1'b0;
    n_checks++;
    if (err !== 1'b1 || wr_req !== 1'b0) begin
      n_fail++;
      $display("FAIL err_set: got err=%b wr_req=%b expected 1 0", err, wr_req);
    end
    rd_gnt = 1'b1; wr_gnt = 1'b1;
    wait_done(50, cyc);
    @(negedge clk);
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky: got %b expected 1", err);
    end
    check_copy("err_copy", 12'h040, 12'h600, 4);
    start_cmd(12'h000, 12'h000, 13'd0);
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear: got %b expected 0", err);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len0();
    test_stall();
    test_wrap();
    test_reset_mid();
    test_err();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
